// File: rtl/multi_adc_stream.sv
// Deserializes NUM_CHANNELS two-lane DDR ADC channels and streams completed sample
// sets out of an AXI4-Stream master, packing two channels per 32-bit beat.

module multi_adc_lane #(
  parameter int SAMPLE_BITS = 14
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   shift_i,
  input  logic                   a_i,
  input  logic                   b_i,
  output logic [SAMPLE_BITS-1:0] nxt_o
);
  // Only the older SAMPLE_BITS-2 bits need storage; the newest pair comes from the lanes.
  logic [SAMPLE_BITS-3:0] sh_q;

  assign nxt_o = {sh_q, a_i, b_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      sh_q <= '0;
    else if (shift_i) sh_q <= nxt_o[SAMPLE_BITS-3:0];
  end
endmodule

module multi_adc_stream #(
  parameter int NUM_CHANNELS  = 4,
  parameter int SAMPLE_BITS   = 14,
  parameter int PACKET_FRAMES = 256,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                    m00_axis_aclk,
  input  logic                    m00_axis_aresetn,
  input  logic                    enable,
  input  logic                    DATA_CLK,
  input  logic                    FRAME_CLK,
  input  logic [NUM_CHANNELS-1:0] CH_A,
  input  logic [NUM_CHANNELS-1:0] CH_B,
  output logic                    m00_axis_tvalid,
  output logic [31:0]             m00_axis_tdata,
  output logic                    m00_axis_tlast,
  input  logic                    m00_axis_tready,
  output logic [15:0]             dropped_frames,
  output logic [15:0]             frame_errors
);
  localparam int NB  = NUM_CHANNELS / 2;
  localparam int NP  = SAMPLE_BITS / 2;
  localparam int PCW = $clog2(NP + 1);
  localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int PW  = (PACKET_FRAMES > 1) ? $clog2(PACKET_FRAMES) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int SW  = 2 * NUM_CHANNELS + 2;

  logic clk, rst_n;
  assign clk   = m00_axis_aclk;
  assign rst_n = m00_axis_aresetn;

  // ---------------- synchronizers ----------------
  logic [SW-1:0] s1_q, s2_q;
  logic [1:0]    s3_q;     // {DATA, FRAME} edge-detect stage
  logic [2:0]    svld_q;   // edges ignored until the chain holds real samples

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      svld_q <= '0;
    end else begin
      s1_q   <= {DATA_CLK, FRAME_CLK, CH_A, CH_B};
      s2_q   <= s1_q;
      s3_q   <= s2_q[SW-1:SW-2];
      svld_q <= {svld_q[1:0], 1'b1};
    end
  end

  logic                    data_edge, frame_rise;
  logic [NUM_CHANNELS-1:0] ch_a_s, ch_b_s;
  assign data_edge  = svld_q[2] & (s2_q[SW-1] ^ s3_q[1]);
  assign frame_rise = svld_q[2] & s2_q[SW-2] & ~s3_q[0];
  assign ch_a_s     = s2_q[2*NUM_CHANNELS-1:NUM_CHANNELS];
  assign ch_b_s     = s2_q[NUM_CHANNELS-1:0];

  // ---------------- capture ----------------
  logic           armed_q;
  logic [PCW-1:0] pcnt_q;
  logic [15:0]    ferr_q, drop_q;
  logic           shift_en, cap_done;

  assign shift_en = data_edge & armed_q & ~frame_rise;
  assign cap_done = shift_en & (pcnt_q == PCW'(NP - 1));

  logic [NUM_CHANNELS-1:0][SAMPLE_BITS-1:0] nxt;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_lane
    multi_adc_lane #(.SAMPLE_BITS(SAMPLE_BITS)) u_lane (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .shift_i(shift_en),
      .a_i    (ch_a_s[i]),
      .b_i    (ch_b_s[i]),
      .nxt_o  (nxt[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
      pcnt_q  <= '0;
      ferr_q  <= '0;
    end else if (frame_rise) begin
      if (armed_q && pcnt_q != '0 && ferr_q != 16'hFFFF) ferr_q <= ferr_q + 16'd1;
      armed_q <= 1'b1;
      pcnt_q  <= '0;
    end else if (shift_en) begin
      if (cap_done) begin
        armed_q <= 1'b0;
        pcnt_q  <= '0;
      end else begin
        pcnt_q  <= pcnt_q + PCW'(1);
      end
    end
  end

  // ---------------- FIFO occupancy (output register counts as a slot) ----------------
  logic [AW:0]   wptr_q, rptr_q, mcnt;
  logic [AW+1:0] occ;
  logic          fits, accept;
  logic          tvalid_q, tlast_q;
  logic [31:0]   tdata_q;

  assign mcnt   = wptr_q - rptr_q;
  assign occ    = {1'b0, mcnt} + (AW+2)'(tvalid_q);
  assign fits   = (occ + (AW+2)'(NB)) <= (AW+2)'(FIFO_DEPTH);

  // ---------------- set writer ----------------
  logic                                     busy_q, last_set_q;
  logic [BW-1:0]                            beat_q;
  logic [PW-1:0]                            pkt_q;
  logic [NUM_CHANNELS-1:0][SAMPLE_BITS-1:0] hold_q;
  logic [NB-1:0][31:0]                      beats;
  logic                                     wr_en, wr_last;
  logic [32:0]                              wdata;

  assign accept = cap_done & enable & ~busy_q & fits;

  for (genvar k = 0; k < NB; k++) begin : g_beat
    assign beats[k] = {16'(hold_q[2*k+1]), 16'(hold_q[2*k])};
  end

  assign wr_en   = busy_q;
  assign wr_last = last_set_q & (beat_q == BW'(NB - 1));
  assign wdata   = {wr_last, beats[beat_q]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= 1'b0;
      last_set_q <= 1'b0;
      beat_q     <= '0;
      pkt_q      <= '0;
      hold_q     <= '0;
      drop_q     <= '0;
    end else begin
      if (accept) begin
        busy_q     <= 1'b1;
        beat_q     <= '0;
        hold_q     <= nxt;
        last_set_q <= (pkt_q == PW'(PACKET_FRAMES - 1));
        pkt_q      <= (pkt_q == PW'(PACKET_FRAMES - 1)) ? '0 : pkt_q + PW'(1);
      end else if (busy_q) begin
        if (beat_q == BW'(NB - 1)) busy_q <= 1'b0;
        beat_q <= beat_q + BW'(1);
      end
      if (cap_done && !accept && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end

  // ---------------- FIFO storage and registered head ----------------
  logic [32:0] mem_q [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + (AW+1)'(1);
      if (!tvalid_q || m00_axis_tready) begin
        tvalid_q <= (mcnt != '0);
        if (mcnt != '0) begin
          {tlast_q, tdata_q} <= mem_q[rptr_q[AW-1:0]];
          rptr_q             <= rptr_q + (AW+1)'(1);
        end
      end
    end
  end

  assign m00_axis_tvalid = tvalid_q;
  assign m00_axis_tdata  = tdata_q;
  assign m00_axis_tlast  = tlast_q;
  assign dropped_frames  = drop_q;
  assign frame_errors    = ferr_q;
endmodule

// File: tb/tb_multi_adc_stream.sv
// Directed bench: a default instance and a small one (2-set packets, 4-beat FIFO)
// share the serial ADC stimulus; output beats are collected and checked per phase.

module tb_multi_adc_stream;
  logic       clk = 0, rst_n = 0, en = 1;
  logic       dclk = 0, fclk = 0;
  logic [3:0] cha = 0, chb = 0;
  logic       rdy_def = 1, rdy_sm = 1;

  logic        d_tvalid, d_tlast, s_tvalid, s_tlast;
  logic [31:0] d_tdata, s_tdata;
  logic [15:0] d_drop, d_ferr, s_drop, s_ferr;

  int n_chk = 0, n_err = 0;
  logic [32:0] q_def[$], q_sm[$];

  always #5 clk = ~clk;

  multi_adc_stream u_def (
    .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n), .enable(en),
    .DATA_CLK(dclk), .FRAME_CLK(fclk), .CH_A(cha), .CH_B(chb),
    .m00_axis_tvalid(d_tvalid), .m00_axis_tdata(d_tdata), .m00_axis_tlast(d_tlast),
    .m00_axis_tready(rdy_def), .dropped_frames(d_drop), .frame_errors(d_ferr));

  multi_adc_stream #(.PACKET_FRAMES(2), .FIFO_DEPTH(4)) u_sm (
    .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n), .enable(en),
    .DATA_CLK(dclk), .FRAME_CLK(fclk), .CH_A(cha), .CH_B(chb),
    .m00_axis_tvalid(s_tvalid), .m00_axis_tdata(s_tdata), .m00_axis_tlast(s_tlast),
    .m00_axis_tready(rdy_sm), .dropped_frames(s_drop), .frame_errors(s_ferr));

  // A beat seen valid&ready here transfers on the following rising edge.
  always @(negedge clk) begin
    if (rst_n && d_tvalid && rdy_def) q_def.push_back({d_tlast, d_tdata});
    if (rst_n && s_tvalid && rdy_sm)  q_sm.push_back({s_tlast, s_tdata});
  end

  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] qget(input bit sm, input int i);
    if (sm) return (i < q_sm.size())  ? q_sm[i]  : 33'h1FFFFFFFF;
    else    return (i < q_def.size()) ? q_def[i] : 33'h1FFFFFFFF;
  endfunction

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame rise, then np bit pairs MSB-first, one pair per DATA_CLK edge (50 ns period).
  task automatic send_set(input logic [15:0] s0, s1, s2, s3, input int np);
    fclk = 1;
    #25;
    for (int j = 0; j < np; j++) begin
      cha = {s3[13-2*j], s2[13-2*j], s1[13-2*j], s0[13-2*j]};
      chb = {s3[12-2*j], s2[12-2*j], s1[12-2*j], s0[12-2*j]};
      #12 dclk = ~dclk;
      #13;
    end
    fclk = 0;
    #30;
    clks(40);
  endtask

  task automatic clr();
    q_def.delete();
    q_sm.delete();
  endtask

  initial begin
    #23;
    chk("rst_tvalid", d_tvalid, 0);
    chk("rst_tlast",  d_tlast, 0);
    chk("rst_tdata",  d_tdata, 0);
    chk("rst_drop",   d_drop, 0);
    chk("rst_ferr",   d_ferr, 0);
    clks(3);
    rst_n = 1;
    clks(5);

    // single set, default packing
    send_set(16'h0A1, 16'h0B1, 16'h0C1, 16'h0D1, 7);
    chk("s1_count", q_def.size(), 2);
    chk("s1_beat0", qget(0, 0), {1'b0, 32'h00B100A1});
    chk("s1_beat1", qget(0, 1), {1'b0, 32'h00D100C1});
    chk("s1_sm_beat1", qget(1, 1), {1'b0, 32'h00D100C1});

    // second set closes a 2-set packet on the small instance
    clr();
    send_set(16'h0A2, 16'h0B2, 16'h0C2, 16'h0D2, 7);
    chk("pkt_sm_b0", qget(1, 0), {1'b0, 32'h00B200A2});
    chk("pkt_sm_b1", qget(1, 1), {1'b1, 32'h00D200C2});
    chk("pkt_def_b1", qget(0, 1), {1'b0, 32'h00D200C2});

    // backpressure: 4-beat FIFO holds two sets, third dropped
    clr();
    @(posedge clk); #1 rdy_sm = 0;
    send_set(16'h0A3, 16'h0B3, 16'h0C3, 16'h0D3, 7);
    send_set(16'h0A4, 16'h0B4, 16'h0C4, 16'h0D4, 7);
    send_set(16'h0A5, 16'h0B5, 16'h0C5, 16'h0D5, 7);
    chk("bp_sm_drop", s_drop, 1);
    chk("bp_def_drop", d_drop, 0);
    chk("bp_hold_valid", s_tvalid, 1);
    chk("bp_hold_data", s_tdata, 32'h00B300A3);
    chk("bp_def_count", q_def.size(), 6);
    @(posedge clk); #1 rdy_sm = 1;
    clks(20);
    chk("bp_sm_count", q_sm.size(), 4);
    chk("bp_sm_b0", qget(1, 0), {1'b0, 32'h00B300A3});
    chk("bp_sm_b1", qget(1, 1), {1'b0, 32'h00D300C3});
    chk("bp_sm_b2", qget(1, 2), {1'b0, 32'h00B400A4});
    chk("bp_sm_b3", qget(1, 3), {1'b1, 32'h00D400C4});

    // restarted frame after 3 pairs
    clr();
    send_set(16'h3FFF, 16'h3FFF, 16'h3FFF, 16'h3FFF, 3);
    chk("fe_nobeats", q_def.size(), 0);
    send_set(16'h0A6, 16'h0B6, 16'h0C6, 16'h0D6, 7);
    chk("fe_ferr", d_ferr, 1);
    chk("fe_sm_ferr", s_ferr, 1);
    chk("fe_count", q_def.size(), 2);
    chk("fe_beat0", qget(0, 0), {1'b0, 32'h00B600A6});
    chk("fe_beat1", qget(0, 1), {1'b0, 32'h00D600C6});

    // capture disabled for one set
    clr();
    en = 0;
    send_set(16'h0A7, 16'h0B7, 16'h0C7, 16'h0D7, 7);
    chk("dis_nobeats", q_def.size(), 0);
    chk("dis_drop", d_drop, 1);
    en = 1;
    send_set(16'h0A8, 16'h0B8, 16'h0C8, 16'h0D8, 7);
    chk("en_count", q_def.size(), 2);
    chk("en_beat0", qget(0, 0), {1'b0, 32'h00B800A8});

    // reset mid-packet with data held in the default FIFO
    @(posedge clk); #1 rdy_def = 0;
    send_set(16'h0A9, 16'h0B9, 16'h0C9, 16'h0D9, 7);
    chk("mid_valid", d_tvalid, 1);
    #3 rst_n = 0;
    #1;
    chk("ar_tvalid", d_tvalid, 0);
    chk("ar_tdata", d_tdata, 0);
    chk("ar_drop", d_drop, 0);
    chk("ar_ferr", d_ferr, 0);
    chk("ar_sm_drop", s_drop, 0);
    clks(3);
    rst_n = 1;
    rdy_def = 1;
    clks(5);
    clr();
    send_set(16'h0AA, 16'h0BA, 16'h0CA, 16'h0DA, 7);
    send_set(16'h0AB, 16'h0BB, 16'h0CB, 16'h0DB, 7);
    chk("ar_def_count", q_def.size(), 4);
    chk("ar_def_b0", qget(0, 0), {1'b0, 32'h00BA00AA});
    chk("ar_def_b3", qget(0, 3), {1'b0, 32'h00DB00CB});
    chk("ar_sm_b1", qget(1, 1), {1'b0, 32'h00DA00CA});
    chk("ar_sm_b3", qget(1, 3), {1'b1, 32'h00DB00CB});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
